// File: rtl/argmax_pkg.sv
// Shared defaults, index widths and FSM state encoding for the argmax result buffer.
// Width helper keeps single-class builds from collapsing to a zero-width index.
package argmax_pkg;

  localparam int FEATURE_ROWS_DEF = 6;
  localparam int WEIGHT_COLS_DEF  = 3;
  localparam int DATA_WIDTH_DEF   = 16;
  localparam int ROW_W            = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int classWidth(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed argmax over a packed vector of class scores.
// Strict greater-than keeps the lowest class index on ties.
module argmax_cmp
  import argmax_pkg::*;
#(
  parameter int WEIGHT_COLS = WEIGHT_COLS_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
  input  logic [WEIGHT_COLS*DATA_WIDTH-1:0]     scores_i,
  output logic [classWidth(WEIGHT_COLS)-1:0]    class_o
);

  localparam int CLASS_W = classWidth(WEIGHT_COLS);

  logic signed [DATA_WIDTH-1:0] best;

  always_comb begin
    best    = $signed(scores_i[0 +: DATA_WIDTH]);
    class_o = '0;
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if ($signed(scores_i[c*DATA_WIDTH +: DATA_WIDTH]) > best) begin
        best    = $signed(scores_i[c*DATA_WIDTH +: DATA_WIDTH]);
        class_o = CLASS_W'(c);
      end
    end
  end

endmodule

// File: rtl/argmax_result_buffer.sv
// Stores one argmax class per feature row, then streams rows out in order over valid/ready.
// Define ARGMAX_VALID_MASK_EN to skip rows that were never written during readout.
module argmax_result_buffer
  import argmax_pkg::*;
#(
  parameter int FEATURE_ROWS = FEATURE_ROWS_DEF,
  parameter int WEIGHT_COLS  = WEIGHT_COLS_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable_write_argmax,
  input  logic [ROW_W-1:0]                      row_number,
  input  logic [WEIGHT_COLS*DATA_WIDTH-1:0]     wr_scores,
  input  logic                                  seq_done,
  input  logic                                  rd_ready,
  output logic                                  rd_valid,
  output logic [ROW_W-1:0]                      rd_row,
  output logic [classWidth(WEIGHT_COLS)-1:0]    rd_class,
  output logic                                  drain_done
);

  localparam int                CLASS_W  = classWidth(WEIGHT_COLS);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(FEATURE_ROWS - 1);

  state_e             state_q;
  logic [ROW_W-1:0]   ptr_q;
  logic [ROW_W-1:0]   ptr_d;
  logic [CLASS_W-1:0] class_q [FEATURE_ROWS];
  logic [CLASS_W-1:0] wrClass;
  logic               writeEn;
  logic               rowValid;
  logic               advance;
`ifdef ARGMAX_VALID_MASK_EN
  logic [FEATURE_ROWS-1:0] written_q;
`endif

  argmax_cmp #(
    .WEIGHT_COLS (WEIGHT_COLS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_cmp (
    .scores_i (wr_scores),
    .class_o  (wrClass)
  );

  // A row is skipped (advanced over without handshake) only when masking is enabled.
  always_comb begin
    writeEn = (state_q == ST_IDLE) && enable_write_argmax &&
              (int'(row_number) < FEATURE_ROWS);
`ifdef ARGMAX_VALID_MASK_EN
    rowValid = written_q[ptr_q];
`else
    rowValid = 1'b1;
`endif
    advance = (state_q == ST_DRAIN) && (!rowValid || rd_ready);
    ptr_d   = ptr_q;
    if (advance) begin
      ptr_d = (ptr_q == LAST_ROW) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        class_q[r] <= '0;
      end
`ifdef ARGMAX_VALID_MASK_EN
      written_q <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
      if (writeEn) begin
        class_q[row_number] <= wrClass;
`ifdef ARGMAX_VALID_MASK_EN
        written_q[row_number] <= 1'b1;
`endif
      end
      case (state_q)
        ST_IDLE:  if (seq_done) state_q <= ST_DRAIN;
        ST_DRAIN: if (advance && (ptr_q == LAST_ROW)) state_q <= ST_DONE;
        ST_DONE:  state_q <= ST_DONE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state, so they hold steady across stalls.
  assign rd_valid   = (state_q == ST_DRAIN) && rowValid;
  assign rd_row     = ptr_q;
  assign rd_class   = (state_q == ST_DRAIN) ? class_q[ptr_q] : '0;
  assign drain_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_argmax_result_buffer.sv
// Self-checking bench for argmax_result_buffer: per-row model, scoreboard queue of expected
// transfers filled when seq_done is driven, drained against the DUT's valid/ready stream.
module tb_argmax_result_buffer;

  localparam int ROWS = 6;

  typedef struct {
    int      row;
    shortint s0;
    shortint s1;
    shortint s2;
    int      cls;
  } vec_t;

  typedef struct {
    int row;
    int cls;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        enable_write_argmax;
  logic [2:0]  row_number;
  logic [47:0] wr_scores;
  logic        seq_done;
  logic        rd_ready;
  logic        rd_valid;
  logic [2:0]  rd_row;
  logic [1:0]  rd_class;
  logic        drain_done;

  int   compared;
  int   mismatched;
  int   modelClass [ROWS];
  bit   modelWritten [ROWS];
  exp_t sbQ [$];
  vec_t vecs [ROWS];

  argmax_result_buffer dut (
    .clk                 (clk),
    .reset               (reset),
    .enable_write_argmax (enable_write_argmax),
    .row_number          (row_number),
    .wr_scores           (wr_scores),
    .seq_done            (seq_done),
    .rd_ready            (rd_ready),
    .rd_valid            (rd_valid),
    .rd_row              (rd_row),
    .rd_class            (rd_class),
    .drain_done          (drain_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void clearModel();
    for (int r = 0; r < ROWS; r++) begin
      modelClass[r]   = 0;
      modelWritten[r] = 1'b0;
    end
    sbQ.delete();
  endfunction

  function automatic void pushExpected();
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
`ifdef ARGMAX_VALID_MASK_EN
      if (!modelWritten[r]) continue;
`endif
      e.row = r;
      e.cls = modelClass[r];
      sbQ.push_back(e);
    end
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".rd_valid"}, int'(rd_valid), 0);
    checkOutput({tag, ".rd_row"}, int'(rd_row), 0);
    checkOutput({tag, ".rd_class"}, int'(rd_class), 0);
    checkOutput({tag, ".drain_done"}, int'(drain_done), 0);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;
    clearModel();
    @(negedge clk);
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic applyStimulus(input int row, input shortint s0, input shortint s1,
                               input shortint s2, input int cls, input bit withDone);
    enable_write_argmax = 1'b1;
    row_number          = row[2:0];
    wr_scores           = {s2, s1, s0};
    seq_done            = withDone;
    if (row < ROWS) begin
      modelClass[row]   = cls;
      modelWritten[row] = 1'b1;
    end
    if (withDone) pushExpected();
    @(negedge clk);
    enable_write_argmax = 1'b0;
    seq_done            = 1'b0;
  endtask

  task automatic startDrain();
    seq_done = 1'b1;
    pushExpected();
    @(negedge clk);
    seq_done = 1'b0;
  endtask

  // readyPat 0: always ready; 1: repeating 1,0,0,1. expCycles < 0 skips the cycle count check.
  task automatic drainAndCheck(input string tag, input int readyPat, input int expCycles);
    int   cycles;
    bit   stalled;
    int   heldRow;
    int   heldClass;
    exp_t e;
    cycles  = 0;
    stalled = 1'b0;
    heldRow = 0;
    heldClass = 0;
    while (!drain_done && cycles < 200) begin
      rd_ready = (readyPat == 0) ? 1'b1 : ((cycles % 4 == 0) || (cycles % 4 == 3));
      if (stalled) begin
        checkOutput({tag, ".stall_valid"}, int'(rd_valid), 1);
        checkOutput({tag, ".stall_row"}, int'(rd_row), heldRow);
        checkOutput({tag, ".stall_class"}, int'(rd_class), heldClass);
      end
      stalled = 1'b0;
      if (rd_valid) begin
        if (rd_ready) begin
          if (sbQ.size() == 0) begin
            checkOutput({tag, ".unexpected_row"}, int'(rd_row), -1);
          end else begin
            e = sbQ.pop_front();
            checkOutput({tag, ".rd_row"}, int'(rd_row), e.row);
            checkOutput({tag, ".rd_class"}, int'(rd_class), e.cls);
          end
        end else begin
          stalled   = 1'b1;
          heldRow   = int'(rd_row);
          heldClass = int'(rd_class);
        end
      end
      cycles++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checkOutput({tag, ".drain_done"}, int'(drain_done), 1);
    checkOutput({tag, ".rows_left"}, sbQ.size(), 0);
    checkOutput({tag, ".valid_after_done"}, int'(rd_valid), 0);
    if (expCycles >= 0) checkOutput({tag, ".cycles"}, cycles, expCycles);
    sbQ.delete();
  endtask

  initial begin
    exp_t e;
    compared            = 0;
    mismatched          = 0;
    reset               = 1'b1;
    enable_write_argmax = 1'b0;
    row_number          = '0;
    wr_scores           = '0;
    seq_done            = 1'b0;
    rd_ready            = 1'b0;

    vecs[0] = '{row: 0, s0: 16'sd1,      s1: 16'sd9,     s2: 16'sd3,     cls: 1};
    vecs[1] = '{row: 1, s0: -16'sd5,     s1: -16'sd5,    s2: -16'sd7,    cls: 0};
    vecs[2] = '{row: 2, s0: 16'sd4,      s1: 16'sd4,     s2: 16'sd4,     cls: 0};
    vecs[3] = '{row: 3, s0: -16'sd3,     s1: -16'sd8,    s2: -16'sd1,    cls: 2};
    vecs[4] = '{row: 4, s0: -16'sd32768, s1: 16'sd32767, s2: 16'sd32767, cls: 1};
    vecs[5] = '{row: 5, s0: -16'sd1,     s1: -16'sd32768, s2: 16'sd0,    cls: 2};

    $display("[TB] phase 1: uniform scores, full-rate drain");
    resetDut();
    for (int r = 0; r < ROWS; r++) applyStimulus(r, 16'sd1, 16'sd9, 16'sd3, 1, 1'b0);
    checkOutput("idle.rd_valid", int'(rd_valid), 0);
    startDrain();
    drainAndCheck("uniform", 0, ROWS);

    $display("[TB] phase 2: table vectors with 1,0,0,1 ready pattern");
    resetDut();
    for (int i = 0; i < ROWS; i++)
      applyStimulus(vecs[i].row, vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].cls, 1'b0);
    startDrain();
    drainAndCheck("table", 1, -1);

    $display("[TB] phase 3: sparse rows, rewrite of row 5, out-of-range writes");
    resetDut();
    applyStimulus(1, 16'sd0,  16'sd5,  16'sd1, 1, 1'b0);
    applyStimulus(2, 16'sd7,  16'sd0,  16'sd0, 0, 1'b0);
    applyStimulus(3, -16'sd1, -16'sd2, 16'sd3, 2, 1'b0);
    applyStimulus(4, 16'sd2,  16'sd8,  16'sd3, 1, 1'b0);
    applyStimulus(5, 16'sd9,  16'sd0,  16'sd0, 0, 1'b0);
    applyStimulus(5, 16'sd0,  16'sd0,  16'sd9, 2, 1'b0);
    applyStimulus(6, 16'sd0,  16'sd0,  16'sd9, 2, 1'b0);
    applyStimulus(7, 16'sd0,  16'sd0,  16'sd9, 2, 1'b0);
    startDrain();
    drainAndCheck("sparse", 0, ROWS);

    $display("[TB] phase 4: reset mid-drain, then restart");
    resetDut();
    for (int r = 0; r < ROWS; r++) applyStimulus(r, 16'sd0, 16'sd9, 16'sd0, 1, 1'b0);
    startDrain();
    for (int k = 0; k < 2; k++) begin
      rd_ready = 1'b1;
      checkOutput("pre_reset.rd_valid", int'(rd_valid), 1);
      e = sbQ.pop_front();
      checkOutput("pre_reset.rd_row", int'(rd_row), e.row);
      checkOutput("pre_reset.rd_class", int'(rd_class), e.cls);
      @(negedge clk);
    end
    rd_ready = 1'b0;
    reset    = 1'b1;
    #1;
    checkIdleOutputs("mid_reset");
    clearModel();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("post_reset");
    for (int r = 0; r < ROWS; r++) begin
      if (r % 2 == 0) applyStimulus(r, 16'sd0, 16'sd0, 16'sd1, 2, r == ROWS - 1);
      else            applyStimulus(r, 16'sd3, 16'sd1, 16'sd2, 0, r == ROWS - 1);
    end
    enable_write_argmax = 1'b1;
    row_number          = 3'd5;
    wr_scores           = {16'sd0, 16'sd9, 16'sd0};
    drainAndCheck("restart", 0, ROWS);
    enable_write_argmax = 1'b0;

    $display("[TB] phase 5: drain with no rows written");
    resetDut();
    startDrain();
    drainAndCheck("empty", 0, ROWS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/argmax_result_buffer.md
ARGMAX_RESULT_BUFFER -- requirements
Module: argmax_result_buffer

Interface
REQ-001 SHALL have parameter FEATURE_ROWS, default 6, number of result rows stored.
REQ-002 SHALL have parameter WEIGHT_COLS, default 3, number of class scores per row.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, width of one signed two's-complement score.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable_write_argmax  input  1  write strobe from the argmax sequencer.
REQ-007 SHALL have port row_number  input  3  row index being written.
REQ-008 SHALL have port wr_scores  input  WEIGHT_COLS*DATA_WIDTH  packed class scores; score c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port seq_done  input  1  sequencer done level; starts readout.
REQ-010 SHALL have port rd_ready  input  1  downstream accepts current result.
REQ-011 SHALL have port rd_valid  output  1  result presented.
REQ-012 SHALL have port rd_row  output  3  row index of presented result.
REQ-013 SHALL have port rd_class  output  $clog2(WEIGHT_COLS)  argmax class of presented row.
REQ-014 SHALL have port drain_done  output  1  all results delivered.

Function
REQ-015 SHALL compute argmax of wr_scores combinationally, signed comparison; on ties the lowest class index wins.
REQ-016 SHALL, in IDLE with enable_write_argmax=1 and row_number<FEATURE_ROWS, store the argmax class into entry row_number and set its written flag at the same edge.
REQ-017 SHALL ignore writes with row_number>=FEATURE_ROWS; repeated writes to one row overwrite (last write wins).
REQ-018 SHALL implement FSM states IDLE, DRAIN, DONE: IDLE->DRAIN when seq_done sampled 1; DRAIN->DONE after the transfer of row FEATURE_ROWS-1 (or after that row is skipped per REQ-027); DONE is terminal until reset.
REQ-019 SHALL, when enable_write_argmax and seq_done are both 1 in IDLE, perform the write and enter DRAIN at the same edge.
REQ-020 SHALL ignore enable_write_argmax in DRAIN and DONE.
REQ-021 SHALL, in DRAIN, present entries in ascending row order from row 0; rd_valid asserts in the first cycle after seq_done is sampled.
REQ-022 SHALL complete a transfer when rd_valid and rd_ready are both 1; the row pointer advances at that edge.
REQ-023 SHALL hold rd_valid, rd_row, rd_class stable while rd_valid=1 and rd_ready=0.
REQ-024 SHALL drive rd_valid=0 outside DRAIN; drain_done=1 exactly in DONE.
REQ-025 SHALL sustain one transfer per cycle with rd_ready held 1 (FEATURE_ROWS consecutive cycles).

Reset
REQ-026 SHALL, on reset (including mid-DRAIN), go to IDLE, clear all stored classes to 0, clear all written flags and the row pointer, and drive rd_valid=0, rd_row=0, rd_class=0, drain_done=0.

Configuration
REQ-027 SHALL, with macro ARGMAX_VALID_MASK_EN defined, skip rows whose written flag is 0: the pointer advances one row per cycle with rd_valid=0; with no row written, DRAIN->DONE after FEATURE_ROWS cycles without asserting rd_valid.
REQ-028 SHALL, without ARGMAX_VALID_MASK_EN, present every row 0..FEATURE_ROWS-1; unwritten rows report rd_class=0.

Structure
REQ-029 SHALL take FEATURE_ROWS/WEIGHT_COLS/DATA_WIDTH defaults, derived index widths and the state enum from shared package argmax_pkg.
REQ-030 SHALL place the combinational argmax comparator in sub-module argmax_cmp (inputs packed scores, output class index).

Verification
REQ-031 SHALL cover: write rows 0..5 with scores (1,9,3) -> rd_class=1 for each row, rows 0..5 delivered in 6 cycles with rd_ready=1, then drain_done=1.
REQ-032 SHALL cover: scores (-5,-5,-7) and (4,4,4) -> rd_class=0 (tie, lowest index); (-3,-8,-1) -> rd_class=2.
REQ-033 SHALL cover: rd_ready toggling 1,0,0,1 during DRAIN -> rd_row/rd_class unchanged while stalled, no row lost or duplicated.
REQ-034 SHALL cover: sequencer pattern rows 1..5 with row 5 written twice, row 0 unwritten -> with macro rows 1..5 delivered; without macro row 0 delivered with rd_class=0; row 5 carries second write.
REQ-035 SHALL cover: reset asserted after 2 transfers in DRAIN -> all outputs 0, state IDLE; new writes and seq_done restart readout at row 0.
REQ-036 SHALL cover: write with row_number=7 -> no entry changed.
